// File: rtl/key_ctrl_mc_pkg.sv
// -----------------------------------------------------------------------------
// key_ctrl_mc_pkg
// Shared definitions for the multi-channel key controller:
//   - key_state_e : per-channel debounce FSM encoding (2 bits)
//   - DEFAULT_DEBOUNCE_CYC : 10 ms at 100 MHz
//   - `KEY_IDX_W(n) : width of an index selecting one of n keys (min 1)
// -----------------------------------------------------------------------------
`ifndef KEY_CTRL_MC_PKG_SV
`define KEY_CTRL_MC_PKG_SV

`define KEY_IDX_W(n) (((n) > 1) ? $clog2(n) : 1)

package key_ctrl_mc_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_e;

  localparam int DEFAULT_DEBOUNCE_CYC = 1_000_000;

endpackage

`endif

// File: rtl/key_ctrl_mc_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-flop synchroniser, debounce FSM with saturating counter,
// registered debounced level and one-cycle press / release pulses.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   raw       : unsynchronised key pin
//   level     : debounced level, 1 = pressed
//   press     : one-cycle pulse when a press is accepted
//   rel       : one-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_ctrl_mc_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam logic          REL_VAL = (ACTIVE_LOW != 0);
  localparam int            CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync_a, sync_b;
  logic          p;
  key_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt, press_nxt, rel_nxt;

  // NOTE: the synchroniser resets to the "released" pin value, not to 0,
  // so an active-low key does not look pressed as reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= REL_VAL;
      sync_b <= REL_VAL;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Normalised: 1 = pressed regardless of pin polarity.
  assign p = sync_b ^ REL_VAL;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;  // stops at CNT_MAX, never wraps
        end
      end
      HELD: begin
        if (!p) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (p) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      press <= press_nxt;
      rel   <= rel_nxt;
    end
  end

endmodule

// File: rtl/key_ctrl_mc.sv
// -----------------------------------------------------------------------------
// key_ctrl_mc
// Multi-channel push-button controller: KEY_NUM debounced channels plus a
// wrapping selection index advanced by presses of key SEL_KEY.
// Optional macro KEY_LONGPRESS_RST_EN: holding key SEL_KEY for LONG_CYC cycles
// raises sw_rst for RST_STRETCH cycles; without it sw_rst is tied to 0.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   key_raw     : unsynchronised key pins
//   key_level   : debounced levels, 1 = pressed
//   key_press   : one-cycle accepted-press pulses
//   key_release : one-cycle accepted-release pulses
//   sel         : selection index, wraps SEL_NUM-1 -> 0
//   sel_chg     : one-cycle pulse aligned with a new sel value
//   sw_rst      : soft-reset request, active-high
// -----------------------------------------------------------------------------
module key_ctrl_mc
  import key_ctrl_mc_pkg::*;
#(
  parameter int KEY_NUM      = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int SEL_KEY      = 0,
  parameter int SEL_NUM      = 4,
  parameter int LONG_CYC     = 200_000_000,
  parameter int RST_STRETCH  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_NUM-1:0]         key_raw,
  output logic [KEY_NUM-1:0]         key_level,
  output logic [KEY_NUM-1:0]         key_press,
  output logic [KEY_NUM-1:0]         key_release,
  output logic [$clog2(SEL_NUM)-1:0] sel,
  output logic                       sel_chg,
  output logic                       sw_rst
);

  localparam int            SW       = $clog2(SEL_NUM);
  localparam logic [SW-1:0] SEL_LAST = SW'(SEL_NUM - 1);
  localparam int            KW       = `KEY_IDX_W(KEY_NUM);
  localparam logic [KW-1:0] SEL_IDX  = KW'(SEL_KEY);

  if (KEY_NUM < 1 || KEY_NUM > 16 || DEBOUNCE_CYC < 2 || SEL_NUM < 2 ||
      SEL_KEY < 0 || SEL_KEY >= KEY_NUM || LONG_CYC < 1 || RST_STRETCH < 1)
  begin : g_bad_cfg
    $error("key_ctrl_mc: parameter out of range");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (key_raw[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rel  (key_release[i])
    );
  end

  // sel and sel_chg update on the same edge, so sel_chg marks the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      sel_chg <= 1'b0;
    end else begin
      sel_chg <= key_press[SEL_IDX];
      if (key_press[SEL_IDX]) begin
        sel <= (sel == SEL_LAST) ? '0 : sel + SW'(1);
      end
    end
  end

`ifdef KEY_LONGPRESS_RST_EN
  localparam int             HW        = $clog2(LONG_CYC + 1);
  localparam int             STW       = $clog2(RST_STRETCH + 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [STW-1:0] STR_MAX   = STW'(RST_STRETCH);

  logic [HW-1:0]  hold_cnt;
  logic [STW-1:0] stretch_cnt;
  logic           armed;
  logic           fire;

  // Fires on the cycle the hold count would reach LONG_CYC; armed blocks a
  // second shot until key_release has been seen.
  assign fire = key_level[SEL_IDX] && armed && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= '0;
      stretch_cnt <= '0;
      armed       <= 1'b1;
    end else begin
      if (!key_level[SEL_IDX]) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end

      if (fire) begin
        armed <= 1'b0;
      end else if (key_release[SEL_IDX]) begin
        armed <= 1'b1;
      end

      // The stretch runs to completion whatever the key does meanwhile.
      if (fire) begin
        stretch_cnt <= STR_MAX;
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - STW'(1);
      end
    end
  end

  assign sw_rst = (stretch_cnt != '0);
`else
  assign sw_rst = 1'b0;
`endif

endmodule

// File: tb/tb_key_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_key_ctrl_mc
// Directed bench for key_ctrl_mc with KEY_NUM=4, DEBOUNCE_CYC=4, SEL_NUM=3,
// LONG_CYC=20, RST_STRETCH=3, ACTIVE_LOW=1. Inputs change on the falling
// edge; a monitor logs pulses 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_key_ctrl_mc;

  localparam int KEY_NUM = 4;
  localparam int DEB     = 4;
  localparam int LAT     = DEB + 2;  // edges from first sampling edge to pulse

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [KEY_NUM-1:0] key_raw = '1;
  logic [KEY_NUM-1:0] key_level, key_press, key_release;
  logic [1:0]         sel;
  logic               sel_chg, sw_rst;

  key_ctrl_mc #(
    .KEY_NUM     (KEY_NUM),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CYC(DEB),
    .SEL_KEY     (0),
    .SEL_NUM     (3),
    .LONG_CYC    (20),
    .RST_STRETCH (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sel        (sel),
    .sel_chg    (sel_chg),
    .sw_rst     (sw_rst)
  );

  always #5 clk = ~clk;

  // Pulse log: counts and cycle stamps of every observed pulse.
  int   cyc = 0;
  int   press_cnt [KEY_NUM];
  int   press_cyc [KEY_NUM];
  int   rel_cnt   [KEY_NUM];
  int   rel_cyc   [KEY_NUM];
  int   chg_cnt   = 0;
  int   chg_cyc   = 0;
  int   chg_sel   = 0;
  int   sw_hi     = 0;
  int   sw_rise   = 0;
  logic sw_prev   = 1'b0;

  initial begin
    for (int i = 0; i < KEY_NUM; i++) begin
      press_cnt[i] = 0; press_cyc[i] = 0; rel_cnt[i] = 0; rel_cyc[i] = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (key_press[i] === 1'b1) begin press_cnt[i]++; press_cyc[i] = cyc; end
      if (key_release[i] === 1'b1) begin rel_cnt[i]++; rel_cyc[i] = cyc; end
    end
    if (sel_chg === 1'b1) begin chg_cnt++; chg_cyc = cyc; chg_sel = int'(sel); end
    if (sw_rst === 1'b1) sw_hi++;
    if (sw_rst === 1'b1 && sw_prev !== 1'b1) sw_rise++;
    sw_prev = sw_rst;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(key_level),   32'd0);
    check({tag, "_press"},   32'(key_press),   32'd0);
    check({tag, "_release"}, 32'(key_release), 32'd0);
    check({tag, "_sel"},     32'(sel),         32'd0);
    check({tag, "_sel_chg"}, 32'(sel_chg),     32'd0);
    check({tag, "_sw_rst"},  32'(sw_rst),      32'd0);
  endtask

  // Press (active-low pin to 0) or release key k at a falling edge, let the
  // debounce finish, and check the pulse latency and count.
  task automatic drive_key(input int k, input logic pressed, input int hold, input string tag);
    int t0, p0, r0;
    @(negedge clk);
    t0 = cyc; p0 = press_cnt[k]; r0 = rel_cnt[k];
    key_raw[k] = ~pressed;
    idle(hold);
    if (pressed) begin
      check({tag, "_press_lat"}, 32'(press_cyc[k] - (t0 + 1)), 32'(LAT));
      check({tag, "_press_n"},   32'(press_cnt[k] - p0),       32'd1);
    end else begin
      check({tag, "_rel_lat"},   32'(rel_cyc[k] - (t0 + 1)),   32'(LAT));
      check({tag, "_rel_n"},     32'(rel_cnt[k] - r0),         32'd1);
    end
  endtask

  initial begin
    int p0, c0, s0;
    logic [1:0] exp_sel [3];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0;

    // Reset: outputs read 0 while rst is high.
    #1 rst = 1'b1;
    idle(3);
    check_all_zero("rst");
    @(negedge clk) rst = 1'b0;
    idle(3);

    // Clean press and release on key 1; other channels stay quiet.
    drive_key(1, 1'b1, 10, "k1");
    check("k1_level_held", 32'(key_level), 32'b0010);
    check("k1_others_press", 32'(press_cnt[0] + press_cnt[2] + press_cnt[3]), 32'd0);
    drive_key(1, 1'b0, 10, "k1");
    check("k1_level_rel", 32'(key_level), 32'b0000);

    // Bounce on key 2: 3 cycles low, 3 high, five times.
    p0 = press_cnt[2];
    for (int b = 0; b < 5; b++) begin
      @(negedge clk) key_raw[2] = 1'b0;
      idle(2);
      @(negedge clk) key_raw[2] = 1'b1;
      idle(2);
    end
    idle(10);
    check("bounce_press_n", 32'(press_cnt[2] - p0), 32'd0);
    check("bounce_level",   32'(key_level[2]),      32'd0);

    // Select: three presses on key 0 wrap 1, 2, 0; the last held 50 cycles.
    for (int n = 0; n < 3; n++) begin
      c0 = chg_cnt;
      drive_key(0, 1'b1, (n == 2) ? 50 : 10, "sel");
      check("sel_value",   32'(sel),                        32'(exp_sel[n]));
      check("sel_chg_n",   32'(chg_cnt - c0),               32'd1);
      check("sel_chg_lag", 32'(chg_cyc - press_cyc[0]),     32'd1);
      check("sel_chg_val", 32'(chg_sel),                    32'(exp_sel[n]));
      drive_key(0, 1'b0, 10, "sel");
    end

    // Simultaneous presses on keys 0 and 3.
    @(negedge clk);
    key_raw[0] = 1'b0; key_raw[3] = 1'b0;
    idle(10);
    check("sim_same_cycle", 32'(press_cyc[3] - press_cyc[0]), 32'd0);
    check("sim_level",      32'(key_level),                   32'b1001);
    check("sim_sel",        32'(sel),                         32'd1);
    @(negedge clk);
    key_raw[0] = 1'b1; key_raw[3] = 1'b1;
    idle(10);
    check("sim_level_rel", 32'(key_level), 32'b0000);

    // Reset mid-debounce on key 1: rst rises with the counter at 2.
    p0 = press_cnt[1];
    @(negedge clk) key_raw[1] = 1'b0;
    idle(4);                 // edges e0..e3 done: FSM in PRESS_WAIT, cnt = 2
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    idle(3);
    check("midrst_press_n", 32'(press_cnt[1] - p0), 32'd0);
    s0 = cyc;
    rst = 1'b0;
    idle(10);
    check("midrst_press_lat", 32'(press_cyc[1] - (s0 + 1)), 32'(LAT));
    check("midrst_press_n2",  32'(press_cnt[1] - p0),       32'd1);
    check("midrst_sel",       32'(sel),                     32'd0);
    drive_key(1, 1'b0, 10, "midrst");

`ifdef KEY_LONGPRESS_RST_EN
    // Long press: one 3-cycle sw_rst per hold; a second press re-arms it.
    for (int n = 0; n < 2; n++) begin
      s0 = sw_rise; c0 = sw_hi;
      drive_key(0, 1'b1, LAT + 30, "long");
      check("long_sw_rise", 32'(sw_rise - s0), 32'd1);
      check("long_sw_len",  32'(sw_hi - c0),   32'd3);
      drive_key(0, 1'b0, 10, "long");
    end
`else
    check("sw_rst_never", 32'(sw_hi), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
